mem_access_unit: RTL and testbench

- Parametrised successor to the pipeline MEM stage's data-memory path.
- Owns the full data-memory transaction for one load/store: alignment check, byte-enable/write-data lane steering, a request FSM that holds the request stable until `dmem_resp`, pipeline stall generation, and load-data extraction with sign/zero extension.
- Sits between the EX/MEM pipeline register and the data cache port. Its outputs feed MEM/WB.

---
 rtl/mem_access_pkg.sv | 43 ++++
 rtl/mem_lane_align.sv | 51 +++++
 rtl/mem_access_unit.sv | 174 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared types and lane constants for the MEM-stage memory path.
package mem_access_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mem_state_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LD  = 3'b011,
      LBU = 3'b100,
      LHU = 3'b101,
      LWU = 3'b110
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010,
      SD = 3'b011
   } store_funct3_t;

   localparam logic [7:0] MASK_B = 8'h01;
   localparam logic [7:0] MASK_H = 8'h03;
   localparam logic [7:0] MASK_W = 8'h0F;
   localparam logic [7:0] MASK_D = 8'hFF;

   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      logic [7:0] m;
      unique case (sz)
         2'b00:   m = MASK_B;
         2'b01:   m = MASK_H;
         2'b10:   m = MASK_W;
         default: m = MASK_D;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational alignment check, lane steering and load extension.
module mem_lane_align
   import mem_access_pkg::*;
#(
   parameter  int WIDTH  = 32,
   localparam int NBYTES = WIDTH / 8,
   localparam int OFFW   = $clog2(NBYTES)
) (
   input  logic [2:0]        req_funct3_i,
   input  logic [OFFW-1:0]   req_off_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [2:0]        ld_funct3_i,
   input  logic [OFFW-1:0]   ld_off_i,
   input  logic [WIDTH-1:0]  rdata_i,
   output logic              misaligned_o,
   output logic [NBYTES-1:0] byte_en_o,
   output logic [WIDTH-1:0]  wdata_o,
   output logic [WIDTH-1:0]  load_data_o
);

   logic [WIDTH-1:0] sh;

   always_comb begin
      misaligned_o = 1'b0;
      unique case (req_funct3_i[1:0])
         2'b00:   misaligned_o = 1'b0;
         2'b01:   misaligned_o = req_off_i[0];
         2'b10:   misaligned_o = |req_off_i[1:0];
         // Double-word has no legal lane on a 32-bit port
         default: misaligned_o = (WIDTH == 32) ? 1'b1 : |req_off_i;
      endcase
   end

   assign byte_en_o = NBYTES'(size_mask(req_funct3_i[1:0])) << req_off_i;
   assign wdata_o   = wdata_i << {req_off_i, 3'b000};
   assign sh        = rdata_i >> {ld_off_i, 3'b000};

   always_comb begin
      load_data_o = sh;
      unique case (ld_funct3_i)
         LB:      load_data_o = WIDTH'($signed(sh[7:0]));
         LH:      load_data_o = WIDTH'($signed(sh[15:0]));
         LW:      load_data_o = WIDTH'($signed(sh[31:0]));
         LBU:     load_data_o = WIDTH'(sh[7:0]);
         LHU:     load_data_o = WIDTH'(sh[15:0]);
         LWU:     load_data_o = WIDTH'(sh[31:0]);
         default: load_data_o = sh;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: one load/store data-memory transaction with stall and load extend.
// Define MEM_ACCESS_PERF_EN to add saturating perf counters.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter  int WIDTH  = 32,
   localparam int NBYTES = WIDTH / 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   input  logic              mem_read_i,
   input  logic              mem_write_i,
   input  logic [2:0]        funct3_i,
   input  logic [WIDTH-1:0]  addr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              flush_i,
   output logic              dmem_read_o,
   output logic              dmem_write_o,
   output logic [WIDTH-1:0]  dmem_address_o,
   output logic [WIDTH-1:0]  dmem_wdata_o,
   output logic [NBYTES-1:0] dmem_byte_en_o,
   input  logic [WIDTH-1:0]  dmem_rdata_i,
   input  logic              dmem_resp_i,
   output logic              stall_o,
   output logic [WIDTH-1:0]  load_data_o,
   output logic              load_valid_o,
   output logic              misaligned_o
`ifdef MEM_ACCESS_PERF_EN
   ,
   output logic [31:0]       perf_req_o,
   output logic [31:0]       perf_stall_o,
   output logic [31:0]       perf_misalign_o
`endif
);

   localparam int OFFW = $clog2(NBYTES);

   mem_state_t        state_q, state_d;
   logic [WIDTH-1:0]  addr_q, addr_d;
   logic [WIDTH-1:0]  wdata_q, wdata_d;
   logic [NBYTES-1:0] be_q, be_d;
   logic [OFFW-1:0]   off_q, off_d;
   logic [2:0]        f3_q, f3_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic              kill_q, kill_d;
   logic [WIDTH-1:0]  ldata_q, ldata_d;

   logic              mis;
   logic [NBYTES-1:0] be_c;
   logic [WIDTH-1:0]  wdata_c;
   logic [WIDTH-1:0]  ld_c;
   logic              busy;
   logic              go;

   mem_lane_align #(.WIDTH(WIDTH)) u_align (
      .req_funct3_i (funct3_i),
      .req_off_i    (addr_i[OFFW-1:0]),
      .wdata_i      (wdata_i),
      .ld_funct3_i  (f3_q),
      .ld_off_i     (off_q),
      .rdata_i      (dmem_rdata_i),
      .misaligned_o (mis),
      .byte_en_o    (be_c),
      .wdata_o      (wdata_c),
      .load_data_o  (ld_c)
   );

   assign go = (state_q == IDLE) & req_valid_i
             & (mem_read_i | mem_write_i) & ~mis & ~flush_i;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      off_d        = off_q;
      f3_d         = f3_q;
      rd_d         = rd_q;
      wr_d         = wr_q;
      kill_d       = kill_q;
      ldata_d      = ldata_q;
      stall_o      = 1'b0;
      load_valid_o = 1'b0;
      misaligned_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            misaligned_o = req_valid_i & (mem_read_i | mem_write_i) & mis;
            if (go) begin
               state_d = BUSY;
               addr_d  = {addr_i[WIDTH-1:OFFW], {OFFW{1'b0}}};
               wdata_d = wdata_c;
               be_d    = be_c;
               off_d   = addr_i[OFFW-1:0];
               f3_d    = funct3_i;
               rd_d    = mem_read_i;
               wr_d    = mem_write_i & ~mem_read_i;
               kill_d  = 1'b0;
               stall_o = 1'b1;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            // The cache keeps going; a flush only hides the result
            if (flush_i) kill_d = 1'b1;
            if (dmem_resp_i) begin
               ldata_d = ld_c;
               state_d = DONE;
            end
         end
         DONE: begin
            load_valid_o = rd_q & ~kill_q & ~flush_i;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         off_q   <= '0;
         f3_q    <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         kill_q  <= 1'b0;
         ldata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         off_q   <= off_d;
         f3_q    <= f3_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         kill_q  <= kill_d;
         ldata_q <= ldata_d;
      end
   end

   assign busy           = (state_q == BUSY);
   assign dmem_read_o    = busy & rd_q;
   assign dmem_write_o   = busy & wr_q;
   assign dmem_address_o = busy ? addr_q : '0;
   assign dmem_wdata_o   = busy ? wdata_q : '0;
   assign dmem_byte_en_o = busy ? be_q : '0;
   assign load_data_o    = ldata_q;

`ifdef MEM_ACCESS_PERF_EN
   logic [31:0] perf_req_q, perf_stall_q, perf_mis_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_req_q   <= '0;
         perf_stall_q <= '0;
         perf_mis_q   <= '0;
      end else begin
         if (go && !(&perf_req_q)) perf_req_q <= perf_req_q + 32'd1;
         if (busy && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
         if (misaligned_o && !(&perf_mis_q)) perf_mis_q <= perf_mis_q + 32'd1;
      end
   end

   assign perf_req_o      = perf_req_q;
   assign perf_stall_o    = perf_stall_q;
   assign perf_misalign_o = perf_mis_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store checks for 32- and 64-bit units.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        rv, mrd, mwr, fl, resp;
   logic [2:0]  f3;
   logic [31:0] addr, wd, rdata;
   logic        d_rd, d_wr, stall, lv, mis;
   logic [31:0] d_addr, d_wd, ldo;
   logic [3:0]  d_be;

   logic        rv64, mrd64, mwr64, fl64, resp64;
   logic [2:0]  f3_64;
   logic [63:0] addr64, wd64, rdata64;
   logic        d_rd64, d_wr64, stall64, lv64, mis64;
   logic [63:0] d_addr64, d_wd64, ldo64;
   logic [7:0]  d_be64;

`ifdef MEM_ACCESS_PERF_EN
   logic [31:0] pr32, ps32, pm32, pr64, ps64, pm64;
`endif

   mem_access_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(rv), .mem_read_i(mrd), .mem_write_i(mwr),
      .funct3_i(f3), .addr_i(addr), .wdata_i(wd), .flush_i(fl),
      .dmem_read_o(d_rd), .dmem_write_o(d_wr),
      .dmem_address_o(d_addr), .dmem_wdata_o(d_wd),
      .dmem_byte_en_o(d_be), .dmem_rdata_i(rdata),
      .dmem_resp_i(resp), .stall_o(stall),
      .load_data_o(ldo), .load_valid_o(lv), .misaligned_o(mis)
`ifdef MEM_ACCESS_PERF_EN
      , .perf_req_o(pr32), .perf_stall_o(ps32), .perf_misalign_o(pm32)
`endif
   );

   mem_access_unit #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst),
      .req_valid_i(rv64), .mem_read_i(mrd64), .mem_write_i(mwr64),
      .funct3_i(f3_64), .addr_i(addr64), .wdata_i(wd64), .flush_i(fl64),
      .dmem_read_o(d_rd64), .dmem_write_o(d_wr64),
      .dmem_address_o(d_addr64), .dmem_wdata_o(d_wd64),
      .dmem_byte_en_o(d_be64), .dmem_rdata_i(rdata64),
      .dmem_resp_i(resp64), .stall_o(stall64),
      .load_data_o(ldo64), .load_valid_o(lv64), .misaligned_o(mis64)
`ifdef MEM_ACCESS_PERF_EN
      , .perf_req_o(pr64), .perf_stall_o(ps64), .perf_misalign_o(pm64)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference rules: access of n bytes must sit on an n-byte boundary
   // and must fit the port width.
   function automatic bit m_mis(input logic [2:0] f, input logic [63:0] a,
                                input int w);
      int n;
      n = 1 << f[1:0];
      if (8 * n > w) return 1'b1;
      return (a % n) != 0;
   endfunction

   function automatic logic [63:0] m_be(input logic [2:0] f,
                                        input logic [63:0] a, input int w);
      int n, off;
      n   = 1 << f[1:0];
      off = int'(a % (w / 8));
      return ((64'd1 << n) - 64'd1) << off;
   endfunction

   function automatic logic [63:0] m_wd(input logic [63:0] d,
                                        input logic [63:0] a, input int w);
      int off;
      logic [63:0] v;
      off = int'(a % (w / 8));
      v   = d << (8 * off);
      if (w == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   function automatic logic [63:0] m_ld(input logic [63:0] r,
                                        input logic [63:0] a,
                                        input logic [2:0] f, input int w);
      int n, off;
      logic [63:0] v, keep;
      n    = 1 << f[1:0];
      off  = int'(a % (w / 8));
      keep = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
      v    = (r >> (8 * off)) & keep;
      if (!f[2] && n < 8 && v[8*n-1]) v = v | ~keep;
      if (w == 32) v = v & 64'hFFFF_FFFF;
      return v;
   endfunction

   task automatic idle32();
      rv = 0; mrd = 0; mwr = 0; f3 = 0; addr = 0; wd = 0;
      fl = 0; resp = 0; rdata = 0;
   endtask

   task automatic txn32(input bit rd, input bit wr, input logic [2:0] fi,
                        input logic [31:0] a, input logic [31:0] wdi,
                        input logic [31:0] rdi, input int dly,
                        input int fl_at);
      int stalls;
      stalls = 0;
      rv = 1; mrd = rd; mwr = wr; f3 = fi; addr = a; wd = wdi;
      #1;
      if (m_mis(fi, 64'(a), 32)) begin
         check("mis_flag", 64'(mis), 1);
         check("mis_stall", 64'(stall), 0);
         check("mis_rd", 64'(d_rd), 0);
         check("mis_wr", 64'(d_wr), 0);
         step();
         idle32();
         #1;
         check("mis_after_stall", 64'(stall), 0);
         return;
      end
      check("acc_mis", 64'(mis), 0);
      check("acc_stall", 64'(stall), 1);
      stalls += int'(stall);
      step();
      for (int k = 1; k <= dly; k++) begin
         resp = (k == dly); rdata = rdi; fl = (k == fl_at);
         #1;
         check("busy_stall", 64'(stall), 1);
         stalls += int'(stall);
         check("busy_rd", 64'(d_rd), 64'(rd));
         check("busy_wr", 64'(d_wr), 64'(wr && !rd));
         check("busy_addr", 64'(d_addr), 64'(a & 32'hFFFF_FFFC));
         check("busy_be", 64'(d_be), m_be(fi, 64'(a), 32));
         check("busy_wd", 64'(d_wd), m_wd(64'(wdi), 64'(a), 32));
         step();
      end
      idle32();
      #1;
      check("done_stall", 64'(stall), 0);
      check("done_lv", 64'(lv), 64'(rd && fl_at == 0));
      check("done_rd", 64'(d_rd), 0);
      if (rd) check("done_ld", 64'(ldo), m_ld(64'(rdi), 64'(a), fi, 32));
      check("stall_cycles", 64'(stalls), 64'(dly + 1));
      step();
      check("idle_lv", 64'(lv), 0);
      check("idle_stall", 64'(stall), 0);
   endtask

   task automatic ld64(input logic [2:0] fi, input logic [63:0] a,
                       input logic [63:0] rdi);
      rv64 = 1; mrd64 = 1; f3_64 = fi; addr64 = a;
      #1;
      check("w64_mis", 64'(mis64), 0);
      check("w64_stall", 64'(stall64), 1);
      step();
      resp64 = 1; rdata64 = rdi;
      #1;
      check("w64_be", 64'(d_be64), m_be(fi, a, 64));
      check("w64_addr", d_addr64, a & 64'hFFFF_FFFF_FFFF_FFF8);
      check("w64_rd", 64'(d_rd64), 1);
      step();
      resp64 = 0; rv64 = 0; mrd64 = 0;
      #1;
      check("w64_lv", 64'(lv64), 1);
      check("w64_ld", ldo64, m_ld(rdi, a, fi, 64));
      step();
   endtask

   logic [2:0]  ldf [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
   logic [2:0]  ld64f [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};

   initial begin
      idle32();
      rv64 = 0; mrd64 = 0; mwr64 = 0; fl64 = 0; resp64 = 0;
      f3_64 = 0; addr64 = 0; wd64 = 0; rdata64 = 0;
      rst = 1;
      step();
      step();
      check("rst_stall", 64'(stall), 0);
      check("rst_rd", 64'(d_rd), 0);
      check("rst_wr", 64'(d_wr), 0);
      check("rst_addr", 64'(d_addr), 0);
      check("rst_lv", 64'(lv), 0);
      check("rst_ld", 64'(ldo), 0);
      check("rst64_ld", ldo64, 0);
      rst = 0;
      step();

      txn32(1'b0, 1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 32'h0, 3, 0);
      txn32(1'b1, 1'b0, 3'b000, 32'h2003, 32'h0, 32'h80123456, 1, 0);
      check("lb_value", 64'(ldo), 64'hFFFF_FF80);
      txn32(1'b1, 1'b0, 3'b100, 32'h2003, 32'h0, 32'h80123456, 1, 0);
      check("lbu_value", 64'(ldo), 64'h0000_0080);
      txn32(1'b0, 1'b1, 3'b001, 32'h3002, 32'h0000ABCD, 32'h0, 1, 0);
      txn32(1'b1, 1'b0, 3'b001, 32'h3001, 32'h0, 32'h0, 1, 0);
      txn32(1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 32'h11223344, 3, 1);
      txn32(1'b1, 1'b0, 3'b011, 32'h5000, 32'h0, 32'h0, 1, 0);

      rv = 1; mwr = 1; f3 = 3'b010; addr = 32'h6008; wd = 32'h12345678;
      step();
      idle32();
      step();
      check("pre_rst_busy", 64'(d_wr), 1);
      rst = 1;
      step();
      rst = 0;
      #1;
      check("midrst_stall", 64'(stall), 0);
      check("midrst_wr", 64'(d_wr), 0);
      check("midrst_be", 64'(d_be), 0);
      check("midrst_wd", 64'(d_wd), 0);
      check("midrst_ld", 64'(ldo), 0);
      resp = 1; rdata = 32'hCAFEF00D;
      step();
      resp = 0;
      #1;
      check("stray_ld", 64'(ldo), 0);
      check("stray_lv", 64'(lv), 0);
      check("stray_stall", 64'(stall), 0);
      step();

      for (int i = 0; i < 40; i++) begin
         bit          isld;
         logic [2:0]  fi;
         logic [31:0] a;
         int          n, dly, fa;
         isld = bit'($urandom_range(0, 1));
         if (isld) fi = ldf[$urandom_range(0, 4)];
         else      fi = 3'($urandom_range(0, 3));
         n = 1 << fi[1:0];
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~(32'(n) - 32'd1);
         dly = $urandom_range(1, 3);
         fa  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, dly) : 0;
         txn32(isld, !isld, fi, a, $urandom, $urandom, dly, fa);
      end

      ld64(3'b011, 64'h10, 64'h0123_4567_89AB_CDEF);
      check("ld_be_lit", 64'(m_be(3'b011, 64'h10, 64)), 64'hFF);
      ld64(3'b010, 64'h14, 64'h1234_5678_0000_0000);
      check("lw64_value", ldo64, 64'h0000_0000_1234_5678);
      for (int i = 0; i < 10; i++) begin
         logic [2:0]  fi;
         logic [63:0] a;
         int          n;
         fi = ld64f[$urandom_range(0, 6)];
         n  = 1 << fi[1:0];
         a  = {32'($urandom), 32'($urandom)} & ~(64'(n) - 64'd1);
         ld64(fi, a, {32'($urandom), 32'($urandom)});
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
